fdivsqrt_postproc_seq: RTL

FDIVSQRT_POSTPROC_SEQ -- requirements
Module: fdivsqrt_postproc_seq

---
 rtl/fdivsqrt_postproc_seq.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fdivsqrt_postproc_seq.sv
// fdivsqrt_postproc_seq: sequential post-processing for a radix divide/sqrt
// recurrence. Resolves the redundant residual WS+WC with a CHUNK-bit
// carry-propagate adder over NCHUNK cycles and derives sign (neg), a nonzero
// flag (sticky) and the corrected quotient Q = neg ? UM : U.
//
// Optional feature: define FDIVSQRT_POSTPROC_FASTZERO_EN to skip the carry
// chain when both captured residual words are zero (latency 1).
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   flush                  synchronous abort, returns to IDLE
//   in_valid / in_ready    operand handshake (ready only in IDLE)
//   WS, WC   [DIVB+3:0]    redundant residual, Q4.DIVB two's complement
//   U, UM    [DIVB:0]      quotient and quotient-minus-ulp
//   out_valid / out_ready  result handshake (valid only in DONE)
//   Q        [DIVB:0]      corrected quotient/root
//   sticky, neg            residual nonzero / residual negative
module fdivsqrt_postproc_seq #(
  parameter int unsigned DIVB  = 56,
  parameter int unsigned CHUNK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DIVB+3:0] WS,
  input  logic [DIVB+3:0] WC,
  input  logic [DIVB:0]   U,
  input  logic [DIVB:0]   UM,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DIVB:0]   Q,
  output logic            sticky,
  output logic            neg
);

  localparam int unsigned W         = DIVB + 4;
  localparam int unsigned NCHUNK    = (W + CHUNK - 1) / CHUNK;
  localparam int unsigned WP        = NCHUNK * CHUNK;
  localparam int unsigned IW        = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned LAST_BITS = W - (NCHUNK - 1) * CHUNK;
  localparam int unsigned NEG_POS   = LAST_BITS - 1;

  // Only the valid residual bits of a partial top chunk feed the nonzero flag.
  localparam logic [CHUNK-1:0] LAST_MASK = {CHUNK{1'b1}} >> (CHUNK - LAST_BITS);
  localparam logic [IW-1:0]    LAST_IDX  = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [WP-1:0]   ws_q, ws_d, wc_q, wc_d;
  logic [DIVB:0]   u_q, u_d, um_q, um_d, q_q, q_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            nz_q, nz_d;
  logic            neg_q, neg_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [CHUNK:0]   csum;
  logic [CHUNK-1:0] cmask;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Q         = q_q;
  assign sticky    = nz_q;
  assign neg       = neg_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ws_q        <= '0;
      wc_q        <= '0;
      u_q         <= '0;
      um_q        <= '0;
      q_q         <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      nz_q        <= 1'b0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ws_q        <= ws_d;
      wc_q        <= wc_d;
      u_q         <= u_d;
      um_q        <= um_d;
      q_q         <= q_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      nz_q        <= nz_d;
      neg_q       <= neg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Current chunk is always the low CHUNK bits; residual words shift down.
  always_comb begin
    csum  = (CHUNK+1)'(ws_q[CHUNK-1:0]) + (CHUNK+1)'(wc_q[CHUNK-1:0])
          + (CHUNK+1)'(carry_q);
    cmask = (idx_q == LAST_IDX) ? LAST_MASK : {CHUNK{1'b1}};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    ws_d    = ws_q;
    wc_d    = wc_q;
    u_d     = u_q;
    um_d    = um_q;
    q_d     = q_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    nz_d    = nz_q;
    neg_d   = neg_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            ws_d    = WP'(WS);
            wc_d    = WP'(WC);
            u_d     = U;
            um_d    = UM;
            carry_d = 1'b0;
            nz_d    = 1'b0;
            idx_d   = '0;
            state_d = S_ADD;
`ifdef FDIVSQRT_POSTPROC_FASTZERO_EN
            // Both words zero: residual is exactly zero, no carry chain needed.
            if ((WS == '0) && (WC == '0)) begin
              neg_d   = 1'b0;
              q_d     = U;
              state_d = S_DONE;
            end
`endif
          end
        end
        S_ADD: begin
          carry_d = csum[CHUNK];
          nz_d    = nz_q | (|(csum[CHUNK-1:0] & cmask));
          ws_d    = ws_q >> CHUNK;
          wc_d    = wc_q >> CHUNK;
          idx_d   = idx_q + IW'(1);
          // Top chunk: sign is residual bit W-1; carry out of it is dropped.
          if (idx_q == LAST_IDX) begin
            neg_d   = csum[NEG_POS];
            q_d     = csum[NEG_POS] ? um_q : u_q;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

endmodule
